// File: rtl/decode_stage.sv
// RV32I decode stage: decodes R/I-type ALU instructions into an execute bundle.
// A registered output slot plus a one-entry skid buffer give full throughput
// under backpressure while keeping o_ready a pure flop output.
module decode_stage #(
  parameter int DATA_WIDTH = 32  // only 32 is meaningful for RV32I
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [4:0]            o_rd,
  output logic [4:0]            o_rs1,
  output logic [4:0]            o_rs2,
  output logic [DATA_WIDTH-1:0] o_imm,
  output logic [3:0]            o_alu_op,
  output logic                  o_alu_src_imm,
  output logic                  o_reg_write,
  output logic                  o_illegal
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4,
    ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR  = 4'd8, ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [DATA_WIDTH-1:0] imm;
    logic [3:0]            alu_op;
    logic                  alu_src_imm;
    logic                  reg_write;
    logic                  illegal;
  } bundle_t;

  bundle_t dec;
  bundle_t out_q, out_d, skid_q, skid_d;
  logic    out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic    acc_in, out_free;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       legal;
  alu_op_e    op;

  assign opc = i_instr[6:0];
  assign f3  = i_instr[14:12];
  assign f7  = i_instr[31:25];

  // Combinational decode of the word currently offered by fetch.
  always_comb begin
    legal           = 1'b0;
    op              = ALU_ADD;
    dec             = '0;
    dec.pc          = i_pc;
    dec.rd          = i_instr[11:7];
    dec.rs1         = i_instr[19:15];
    dec.rs2         = i_instr[24:20];
    dec.imm         = {{(DATA_WIDTH-12){i_instr[31]}}, i_instr[31:20]};
    dec.alu_src_imm = 1'b0;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    if (opc == OPC_R) begin
      // funct7 alternate form only exists for sub and sra
      legal   = (f7 == F7_BASE) || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
      if (f3 == 3'b000 && f7 == F7_ALT) op = ALU_SUB;
      dec.imm = '0;
    end else if (opc == OPC_I) begin
      case (f3)
        3'b001:  legal = (f7 == F7_BASE);
        3'b101:  legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        default: legal = 1'b1;
      endcase
      // shifts carry a zero-extended shamt instead of a signed immediate
      if (f3 == 3'b001 || f3 == 3'b101)
        dec.imm = {{(DATA_WIDTH-5){1'b0}}, i_instr[24:20]};
      dec.rs2         = '0;
      dec.alu_src_imm = 1'b1;
    end
    if (legal) begin
      dec.alu_op    = op;
      dec.reg_write = (dec.rd != 5'd0);
      dec.illegal   = 1'b0;
    end else begin
      // illegal words keep raw register fields but must not write or use imm
      dec.rs2         = i_instr[24:20];
      dec.imm         = {{(DATA_WIDTH-12){i_instr[31]}}, i_instr[31:20]};
      dec.alu_op      = ALU_ADD;
      dec.alu_src_imm = 1'b0;
      dec.reg_write   = 1'b0;
      dec.illegal     = 1'b1;
    end
  end

  assign acc_in   = i_valid && o_ready && !i_flush;
  assign out_free = !out_vld_q || i_ready;

  // Next state of output slot and skid: skid always drains first to keep order.
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (i_flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (out_free) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = acc_in;
        if (acc_in) skid_d = dec;
      end else begin
        out_vld_d = acc_in;
        if (acc_in) out_d = dec;
      end
    end else if (acc_in) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  // State registers; reset discards everything in flight.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign o_ready       = !skid_vld_q;
  assign o_valid       = out_vld_q;
  assign o_pc          = out_q.pc;
  assign o_rd          = out_q.rd;
  assign o_rs1         = out_q.rs1;
  assign o_rs2         = out_q.rs2;
  assign o_imm         = out_q.imm;
  assign o_alu_op      = out_q.alu_op;
  assign o_alu_src_imm = out_q.alu_src_imm;
  assign o_reg_write   = out_q.reg_write;
  assign o_illegal     = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed test-plan cases plus a randomized stream
// scored against a queue-based reference of the decode rules.
module tb_decode_stage;

  logic        gclk = 1'b0;
  logic        i_reset_n;
  logic [31:0] i_instr, i_pc;
  logic        i_valid, i_ready, i_flush;
  logic        o_ready, o_valid;
  logic [31:0] o_pc, o_imm;
  logic [4:0]  o_rd, o_rs1, o_rs2;
  logic [3:0]  o_alu_op;
  logic        o_alu_src_imm, o_reg_write, o_illegal;

  always #5 gclk = ~gclk;

  decode_stage #(.DATA_WIDTH(32)) dut (
    .i_clk(gclk), .i_reset_n(i_reset_n), .i_instr(i_instr), .i_pc(i_pc),
    .i_valid(i_valid), .o_ready(o_ready), .i_flush(i_flush), .o_valid(o_valid),
    .i_ready(i_ready), .o_pc(o_pc), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2),
    .o_imm(o_imm), .o_alu_op(o_alu_op), .o_alu_src_imm(o_alu_src_imm),
    .o_reg_write(o_reg_write), .o_illegal(o_illegal)
  );

  typedef struct {
    logic [31:0] pc, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [3:0]  op;
    logic        src, we, ill;
  } exp_t;

  int n_cmp = 0;
  int n_err = 0;
  exp_t q[$];
  logic         hold_prev = 1'b0;
  logic [127:0] prev_b;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode: straight from the instruction-set rules.
  function automatic exp_t ref_dec(input logic [31:0] w, input logic [31:0] pc);
    logic [3:0] r_ops [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    exp_t e;
    e.pc = pc; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    e.imm = 32'd0; e.op = 4'd0; e.src = 1'b0; e.ill = 1'b1;
    if (w[6:0] == 7'h33) begin
      if (f7 == 7'h00) begin e.ill = 0; e.op = r_ops[f3]; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin e.ill = 0; e.op = 4'd1; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin e.ill = 0; e.op = 4'd7; end
    end else if (w[6:0] == 7'h13) begin
      e.rs2 = 5'd0; e.src = 1'b1;
      e.imm = {{20{w[31]}}, w[31:20]};
      if (f3 == 3'd1) begin
        if (f7 == 7'h00) begin e.ill = 0; e.op = 4'd2; e.imm = {27'd0, w[24:20]}; end
      end else if (f3 == 3'd5) begin
        if (f7 == 7'h00 || f7 == 7'h20) begin
          e.ill = 0; e.op = (f7 == 7'h20) ? 4'd7 : 4'd6; e.imm = {27'd0, w[24:20]};
        end
      end else begin
        e.ill = 0; e.op = r_ops[f3];
      end
    end
    if (e.ill) e.op = 4'd0;
    e.we = !e.ill && (e.rd != 5'd0);
    return e;
  endfunction

  function automatic logic [127:0] cur_b();
    return {42'd0, o_pc, o_rd, o_rs1, o_rs2, o_imm, o_alu_op, o_alu_src_imm, o_reg_write, o_illegal};
  endfunction

  // Called at a falling edge: apply inputs, score, advance one cycle.
  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                      input logic rdy, input logic fl, output logic acc);
    int held = q.size();
    exp_t e;
    i_valid = v; i_instr = w; i_pc = pc; i_ready = rdy; i_flush = fl;
    chk("o_valid", 128'(o_valid), 128'(held > 0));
    chk("o_ready", 128'(o_ready), 128'(held < 2));
    if (hold_prev) chk("hold", cur_b(), prev_b);
    if (held > 0 && rdy) begin
      e = q.pop_front();
      if (e.ill)
        chk("bundle_ill", {88'd0, o_pc, o_rd, o_rs1, o_alu_op, o_reg_write, o_illegal},
            {88'd0, e.pc, e.rd, e.rs1, e.op, e.we, e.ill});
      else
        chk("bundle", cur_b(),
            {42'd0, e.pc, e.rd, e.rs1, e.rs2, e.imm, e.op, e.src, e.we, e.ill});
    end
    hold_prev = o_valid && !rdy && !fl;
    prev_b    = cur_b();
    acc = v && (held < 2) && !fl;
    if (fl) q.delete();
    else if (acc) q.push_back(ref_dec(w, pc));
    @(posedge gclk);
    @(negedge gclk);
  endtask

  function automatic logic [6:0] pick_f7();
    int r = $urandom_range(0, 3);
    if (r < 2) return 7'h00;
    if (r == 2) return 7'h20;
    return 7'($urandom);
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 7);
    if (k < 3) begin
      w[6:0] = 7'h33; w[31:25] = pick_f7();
    end else if (k < 6) begin
      w[6:0] = 7'h13;
      if (w[14:12] == 3'd1 || w[14:12] == 3'd5) w[31:25] = pick_f7();
    end
    return w;
  endfunction

  logic acc;
  int   tries;

  initial begin
    i_reset_n = 1'b0; i_valid = 0; i_instr = 0; i_pc = 0; i_ready = 0; i_flush = 0;
    repeat (3) @(negedge gclk);
    chk("rst.o_valid", 128'(o_valid), 128'(0));
    chk("rst.o_ready", 128'(o_ready), 128'(1));
    chk("rst.bundle", cur_b(), 128'(0));
    i_reset_n = 1'b1;

    // add x2,x0,x1
    step(1, 32'h00100133, 32'h0, 1, 0, acc);
    chk("add.valid", 128'(o_valid), 128'(1));
    chk("add.fields", {88'd0, o_rd, o_rs1, o_rs2, o_alu_op, o_alu_src_imm, o_reg_write, o_illegal},
        {88'd0, 5'd2, 5'd0, 5'd1, 4'd0, 1'b0, 1'b1, 1'b0});
    // sub then sll back-to-back
    step(1, 32'h401282B3, 32'h4, 1, 0, acc);
    chk("sub.fields", {104'd0, o_rd, o_rs1, o_rs2, o_alu_op, o_pc[3:0]},
        {104'd0, 5'd5, 5'd5, 5'd1, 4'd1, 4'd4});
    step(1, 32'h00231133, 32'h8, 1, 0, acc);
    chk("sll.fields", {104'd0, o_rd, o_rs1, o_rs2, o_alu_op, o_pc[3:0]},
        {104'd0, 5'd2, 5'd6, 5'd2, 4'd2, 4'd8});
    // addi x1,x0,-1 and addi x0
    step(1, 32'hFFF00093, 32'hC, 1, 0, acc);
    chk("addi.imm", 128'(o_imm), 128'(32'hFFFFFFFF));
    chk("addi.ctl", {116'd0, o_rs2, o_alu_src_imm, o_alu_op, o_reg_write, o_illegal},
        {116'd0, 5'd0, 1'b1, 4'd0, 1'b1, 1'b0});
    step(1, 32'h00000013, 32'h10, 1, 0, acc);
    chk("nop.we", 128'(o_reg_write), 128'(0));
    // illegal words
    step(1, 32'h00000000, 32'h14, 1, 0, acc);
    chk("ill0", {124'd0, o_illegal, o_reg_write, o_alu_op[1:0]}, {124'd0, 1'b1, 1'b0, 2'd0});
    step(1, 32'h60005013, 32'h18, 1, 0, acc);
    chk("ill_srai", {124'd0, o_illegal, o_reg_write, o_alu_op[1:0]}, {124'd0, 1'b1, 1'b0, 2'd0});
    step(0, 32'h0, 32'h0, 1, 0, acc);
    chk("ill.once", 128'(o_valid), 128'(0));

    // backpressure: PCs 0,4,8,12, i_ready low 3 cycles after the first
    step(1, 32'h00100133, 32'h0, 1, 0, acc);
    step(1, 32'h00208193, 32'h4, 0, 0, acc);
    chk("skid.ready", 128'(o_ready), 128'(0));
    chk("skid.pc0", 128'(o_pc), 128'(0));
    step(1, 32'h40315233, 32'h8, 0, 0, acc);
    step(1, 32'h40315233, 32'h8, 0, 0, acc);
    chk("skid.pc0b", 128'(o_pc), 128'(0));
    for (int i = 2; i < 4; i++) begin
      tries = 0;
      do begin
        step(1, (i == 2) ? 32'h40315233 : 32'h0042E313, 32'(i * 4), 1, 0, acc);
        tries++;
      end while (!acc && tries < 10);
      chk("skid.accept", 128'(acc), 128'(1));
    end
    repeat (3) step(0, 32'h0, 32'h0, 1, 0, acc);
    chk("skid.drained", 128'(q.size()), 128'(0));

    // flush with skid full
    step(1, 32'h00100133, 32'h100, 0, 0, acc);
    step(1, 32'h00100133, 32'h104, 0, 0, acc);
    chk("fl.full", 128'(o_ready), 128'(0));
    step(1, 32'h00100133, 32'h108, 0, 1, acc);
    chk("fl.valid", 128'(o_valid), 128'(0));
    chk("fl.ready", 128'(o_ready), 128'(1));
    step(1, 32'h00A00513, 32'h200, 1, 0, acc);
    chk("fl.first", {95'd0, o_valid, o_pc}, {95'd0, 1'b1, 32'h200});
    step(0, 32'h0, 32'h0, 1, 0, acc);

    // reset while holding two instructions
    step(1, 32'h00100133, 32'h300, 0, 0, acc);
    step(1, 32'h00100133, 32'h304, 0, 0, acc);
    i_reset_n = 1'b0;
    #1;
    chk("mrst.valid", 128'(o_valid), 128'(0));
    chk("mrst.ready", 128'(o_ready), 128'(1));
    q.delete();
    hold_prev = 1'b0;
    @(negedge gclk);
    i_reset_n = 1'b1;

    // randomized stream
    for (int n = 0; n < 3000; n++) begin
      logic fl  = ($urandom_range(0, 49) == 0);
      logic rdy = fl ? 1'b0 : ($urandom_range(0, 2) != 0);
      step($urandom_range(0, 3) != 0, rnd_instr(), $urandom & 32'hFFFFFFFC, rdy, fl, acc);
    end
    repeat (4) step(0, 32'h0, 32'h0, 1, 0, acc);
    chk("end.drained", 128'(q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined RV32I instruction decode stage between instruction fetch and execute in the data path.
- Inverse of the team's instruction assembler: accepts 32-bit encoded words with their PC and recovers register indices, ALU operation, immediate and control flags.
- Valid/ready on both sides, a registered output stage plus a 1-entry skid buffer (full throughput under backpressure), flush support and illegal-instruction flagging.

Parameters:
- DATA_WIDTH, 32, instruction/PC/immediate width; only 32 is supported.

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_reset_n  input  1  asynchronous active-low reset
- i_instr  input  32  encoded instruction from fetch
- i_pc  input  32  PC of i_instr
- i_valid  input  1  fetch presents i_instr/i_pc
- o_ready  output  1  stage can accept this cycle
- i_flush  input  1  discard all held instructions
- o_valid  output  1  decoded bundle valid
- i_ready  input  1  execute accepts bundle
- o_pc  output  32  PC of bundle
- o_rd  output  5  destination register
- o_rs1  output  5  source register 1
- o_rs2  output  5  source register 2 (0 for I-type)
- o_imm  output  32  sign-extended I-immediate (shamt zero-extended for shifts); 0 for R-type
- o_alu_op  output  4  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9
- o_alu_src_imm  output  1  1 = operand B is o_imm
- o_reg_write  output  1  write rd; forced 0 when rd==0 or illegal
- o_illegal  output  1  instruction not in supported set

Behaviour:
- Reset (async assert, sync release): o_valid=0, skid empty, o_ready=1, all bundle outputs 0.
- Supported: opcode 0110011 (R) with funct3/funct7 pairs add,sub,sll,slt,sltu,xor,srl,sra,or,and; opcode 0010011 (I) addi,slti,sltiu,xori,ori,andi,slli,srli,srai.
- For slli/srli/srai, instr[31:25] must be 0000000 (slli/srli) or 0100000 (srai); other funct7 values are illegal. R-type funct7 must be 0000000, or 0100000 only for sub/sra.
- Illegal word: o_illegal=1, o_reg_write=0, o_alu_op=ADD, other fields still extracted raw. The bundle still flows through handshake.
- Transfer in: i_valid && o_ready. Transfer out: o_valid && i_ready.
- Latency: 1 cycle from accepted input to o_valid when output register empty or being drained.
- Output register loads decoded input if empty or draining this cycle; otherwise decoded input goes to skid.
- When output drains and skid full: skid moves to output. If a new input arrives in the same cycle, it goes to skid. Order preserved.
- o_ready = !skid_full, registered, with no combinational path from i_ready.
- Bundle outputs are held stable while o_valid && !i_ready.
- i_flush (synchronous, highest priority): next cycle o_valid=0, skid empty, o_ready=1. An input presented in the flush cycle is dropped even if o_ready was 1.
- Reset mid-operation: all held instructions discarded immediately.
- Sequence i_valid=1 continuous with i_ready toggling never loses or duplicates an instruction.

Test Plan:
- Reset, then 0x00100133 (add x2,x0,x1), i_ready=1 -> next cycle o_valid=1, rd=2, rs1=0, rs2=1, alu_op=0, alu_src_imm=0, reg_write=1, illegal=0.
- 0x401282B3 (sub x5,x5,x1) then 0x00231133 (sll x2,x6,x2) back-to-back -> consecutive bundles alu_op=1 (rd=5, rs1=5, rs2=1), then alu_op=2 (rd=2, rs1=6, rs2=2), one per cycle.
- 0xFFF00093 (addi x1,x0,-1) -> imm=0xFFFFFFFF, alu_src_imm=1, rs2=0, alu_op=0; 0x00000013 (addi x0) -> reg_write=0.
- 0x00000000 and 0x60005013 (srai with bad funct7) -> o_illegal=1, o_reg_write=0, each bundle delivered once.
- Stream 4 instrs at PCs 0,4,8,12 with i_ready low 3 cycles after the first -> o_ready falls after skid fills, bundle PC 0 held stable, then PCs 0,4,8,12 out in order with no loss.
- Skid full and i_flush=1 with i_valid=1 -> next cycle o_valid=0, o_ready=1; the next accepted instr is the first output seen.
